// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 16x-oversampling UART receiver (8N1, LSB first) with a one-byte
//            buffer, sticky frame/overrun flags. Defining UART_RX_PARITY_EN
//            adds an even-parity bit and a sticky parity_err output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int DVSR     = 651,
    parameter int DVSR_W   = 10,
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_empty,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int                c_n_w      = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [DVSR_W-1:0] c_div_max  = DVSR_W'(DVSR - 1);
    localparam logic [c_n_w-1:0]  c_n_last   = c_n_w'(DBIT - 1);
    localparam logic [3:0]        c_sb_last  = 4'(SB_TICK - 1);
    localparam logic [3:0]        c_mid_tick = 4'd7;
    localparam logic [3:0]        c_bit_tick = 4'd15;

    generate
        if (CLK_FREQ < 16 * DVSR || (2 ** DVSR_W) <= DVSR) begin : g_cfg_err
            $error("uart_rx: DVSR does not fit DVSR_W or exceeds CLK_FREQ/16");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        ,
        ST_PARITY = 3'd4
`endif
    } state_t;

    logic              r_rx_meta;
    logic              r_rx_s;
    logic [DVSR_W-1:0] r_div_cnt;
    logic              w_s_tick;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_s_cnt;
    logic [3:0]        w_s_cnt_nxt;
    logic [c_n_w-1:0]  r_n_cnt;
    logic [c_n_w-1:0]  w_n_cnt_nxt;
    logic [DBIT-1:0]   r_shift;
    logic [DBIT-1:0]   w_shift_nxt;
    logic              w_frame_good;
    logic              w_frame_bad;

    logic [DBIT-1:0]   r_rx_data;
    logic              r_rx_empty;
    logic              r_done_tick;
    logic              r_frame_err;
    logic              r_overrun;
    logic              w_pop;

`ifdef UART_RX_PARITY_EN
    logic              w_par_sample;
    logic              r_parity_err;
`endif

    // Two-flop synchronizer; resets to the idle level so no false start edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Free-running oversample divider, never re-phased to the start edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_cnt <= '0;
        end else if (w_s_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DVSR_W'(1);
        end
    end

    assign w_s_tick = (r_div_cnt == c_div_max);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_s_cnt <= '0;
            r_n_cnt <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s_cnt <= w_s_cnt_nxt;
            r_n_cnt <= w_n_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_s_cnt_nxt  = r_s_cnt;
        w_n_cnt_nxt  = r_n_cnt;
        w_shift_nxt  = r_shift;
        w_frame_good = 1'b0;
        w_frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = ST_START;
                    w_s_cnt_nxt = '0;
                end
            end
            ST_START: begin
                if (w_s_tick) begin
                    if (r_s_cnt == c_mid_tick) begin
                        // A line that is high again at mid start bit was a glitch.
                        if (!r_rx_s) begin
                            w_state_nxt = ST_DATA;
                            w_s_cnt_nxt = '0;
                            w_n_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_s_tick) begin
                    if (r_s_cnt == c_bit_tick) begin
                        w_s_cnt_nxt = '0;
                        w_shift_nxt = {r_rx_s, r_shift[DBIT-1:1]};
                        if (r_n_cnt == c_n_last) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = ST_PARITY;
`else
                            w_state_nxt = ST_STOP;
`endif
                        end else begin
                            w_n_cnt_nxt = r_n_cnt + c_n_w'(1);
                        end
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_s_tick) begin
                    if (r_s_cnt == c_bit_tick) begin
                        w_s_cnt_nxt  = '0;
                        w_par_sample = 1'b1;
                        w_state_nxt  = ST_STOP;
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (w_s_tick) begin
                    if (r_s_cnt == c_sb_last) begin
                        w_state_nxt  = ST_IDLE;
                        w_frame_good = r_rx_s;
                        w_frame_bad  = ~r_rx_s;
                    end else begin
                        w_s_cnt_nxt = r_s_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_pop = rd_uart & ~r_rx_empty;

    // Pop is applied before the load, so a same-cycle read frees the slot.
    // Flags clear on any rd_uart, even with the buffer already empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_data   <= '0;
            r_rx_empty  <= 1'b1;
            r_done_tick <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done_tick <= w_frame_good;
            if (rd_uart) begin
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (w_frame_bad) begin
                r_frame_err <= 1'b1;
            end
            if (w_frame_good) begin
                if (r_rx_empty || w_pop) begin
                    r_rx_data  <= r_shift;
                    r_rx_empty <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_pop) begin
                r_rx_empty <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_parity_err <= 1'b0;
        end else if (w_par_sample && ((^r_shift) ^ r_rx_s)) begin
            r_parity_err <= 1'b1;
        end else if (rd_uart) begin
            r_parity_err <= 1'b0;
        end
    end

    assign parity_err = r_parity_err;
`endif

    assign rx_data      = r_rx_data;
    assign rx_empty     = r_rx_empty;
    assign rx_done_tick = r_done_tick;
    assign frame_err    = r_frame_err;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx: frame-level model plus
//            hand-computed literal expectations (honours UART_RX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int DVSR     = 10;
    localparam int BIT_CLKS = 16 * DVSR;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       rx      = 1'b1;
    logic       rd_uart = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_done_tick;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(
        .DVSR    (DVSR),
        .DVSR_W  (10),
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .rd_uart      (rd_uart),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .overrun      (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Frame-level model of the buffer and flags; updated once a frame is over.
    logic [7:0] m_data    = 8'h00;
    logic       m_empty   = 1'b1;
    logic       m_ferr    = 1'b0;
    logic       m_ovr     = 1'b0;
    logic       m_perr    = 1'b0;
    logic [7:0] m_pend    = 8'h00;
    int         m_sent    = 0;
    int         n_done    = 0;
    bit         settled   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rx_done_tick === 1'b1) begin
                n_done++;
                check("done_expected", 32'(n_done <= m_sent), 32'd1);
                check("done_rx_empty", 32'(rx_empty), 32'd0);
                check("done_rx_data", 32'(rx_data), 32'(m_empty ? m_pend : m_data));
            end
            if (settled) begin
                check("rx_data", 32'(rx_data), 32'(m_data));
                check("rx_empty", 32'(rx_empty), 32'(m_empty));
                check("frame_err", 32'(frame_err), 32'(m_ferr));
                check("overrun", 32'(overrun), 32'(m_ovr));
`ifdef UART_RX_PARITY_EN
                check("parity_err", 32'(parity_err), 32'(m_perr));
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_bad);
        settled = 1'b0;
        if (stop_ok) begin
            m_pend = b;
            m_sent++;
        end
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            drive_bit(b[i], BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_bad, BIT_CLKS);
`endif
        if (stop_ok) begin
            drive_bit(1'b1, BIT_CLKS);
        end else begin
            // Low only past the stop sample point so the receiver's restart
            // on the still-low line is rejected as a glitch at mid start bit.
            drive_bit(1'b0, (BIT_CLKS * 3) / 4);
            drive_bit(1'b1, 2 * BIT_CLKS);
        end
        if (stop_ok) begin
            if (m_empty) begin
                m_data  = b;
                m_empty = 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
        end else begin
            m_ferr = 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        if (par_bad) m_perr = 1'b1;
`endif
        check("done_count", 32'(n_done), 32'(m_sent));
        settled = 1'b1;
    endtask

    task automatic read_byte();
        settled = 1'b0;
        @(negedge clk);
        rd_uart = 1'b1;
        @(negedge clk);
        rd_uart = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
        m_empty = 1'b1;
        settled = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_empty", 32'(rx_empty), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_done_tick", 32'(rx_done_tick), 32'd0);
        settled = 1'b1;
        reset   = 1'b1;
        repeat (20 * BIT_CLKS) @(negedge clk);
        check("idle_no_done", 32'(n_done), 32'd0);

        // Single byte, then pop
        send_frame(8'h54, 1'b1, 1'b0);
        check("byte54_data", 32'(rx_data), 32'h54);
        check("byte54_empty", 32'(rx_empty), 32'd0);
        check("byte54_done", 32'(n_done), 32'd1);
        read_byte();
        check("pop_empty", 32'(rx_empty), 32'd1);
        check("pop_data_held", 32'(rx_data), 32'h54);

        // Short low pulse, well under half a bit
        @(negedge clk);
        drive_bit(1'b0, 40);
        drive_bit(1'b1, 2 * BIT_CLKS);
        check("glitch_no_done", 32'(n_done), 32'd1);
        check("glitch_empty", 32'(rx_empty), 32'd1);
        send_frame(8'hDF, 1'b1, 1'b0);
        check("byteDF_data", 32'(rx_data), 32'hDF);
        read_byte();

        // Bad stop bit
        send_frame(8'hA5, 1'b0, 1'b0);
        check("ferr_set", 32'(frame_err), 32'd1);
        check("ferr_empty", 32'(rx_empty), 32'd1);
        check("ferr_no_done", 32'(n_done), 32'd2);
        read_byte();
        check("ferr_cleared", 32'(frame_err), 32'd0);

        // Overrun: second byte dropped
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_done", 32'(n_done), 32'd4);
        read_byte();
        check("ovr_pop_empty", 32'(rx_empty), 32'd1);
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Reset mid-frame wipes the buffer and aborts the frame
        send_frame(8'h3C, 1'b1, 1'b0);
        check("byte3C_data", 32'(rx_data), 32'h3C);
        settled = 1'b0;
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            drive_bit(i[0], BIT_CLKS);
        end
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        m_data  = 8'h00;
        m_empty = 1'b1;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        m_perr  = 1'b0;
        check("midrst_empty", 32'(rx_empty), 32'd1);
        check("midrst_data", 32'(rx_data), 32'h00);
        reset   = 1'b1;
        settled = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge clk);
        check("midrst_no_done", 32'(n_done), 32'd5);

        send_frame(8'h81, 1'b1, 1'b0);
        check("byte81_data", 32'(rx_data), 32'h81);
        read_byte();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h54, 1'b1, 1'b1);
        check("par_bad_data", 32'(rx_data), 32'h54);
        check("par_bad_flag", 32'(parity_err), 32'd1);
        read_byte();
        check("par_cleared", 32'(parity_err), 32'd0);
        send_frame(8'h54, 1'b1, 1'b0);
        check("par_good_flag", 32'(parity_err), 32'd0);
        read_byte();
`endif

        repeat (4) @(negedge clk);
        check("all_done_seen", 32'(n_done), 32'(m_sent));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
